// File: rtl/pe_dot_sequencer.sv
// pe_dot_sequencer: feeds (activation, weight) pairs into the fp16 MAC
// processing element. After VEC_LEN pairs it waits for the last product to
// land, captures the accumulated dot product and presents it on a
// valid/ready output. It then pulses pe_clear so the next window starts
// from zero. No arithmetic is done here.
module pe_dot_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int VEC_LEN    = 9,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic [DATA_WIDTH-1:0] pe_a,
  output logic [DATA_WIDTH-1:0] pe_b,
  output logic                  pe_clear,
  input  logic [DATA_WIDTH-1:0] pe_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    FEED    = 2'd0,
    DRAIN   = 2'd1,
    CAPTURE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  // Counter value held while the final pair of a window is accepted.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic [DATA_WIDTH-1:0] pe_a_nxt_s;
  logic [DATA_WIDTH-1:0] pe_b_nxt_s;
  logic                  pe_clear_nxt_s;
  logic                  out_valid_nxt_s;
  logic [DATA_WIDTH-1:0] out_data_nxt_s;
  logic                  busy_nxt_s;
  logic                  accept_s;
  logic                  last_s;

  assign in_ready = (state_r == FEED);
  assign accept_s = in_valid && (state_r == FEED);
  assign last_s   = (cnt_r == LAST_CNT);

  // State register; reset drops any partially fed window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FEED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: feed -> drain -> capture -> output -> feed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FEED: begin
        if (accept_s && last_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = FEED;
        end
      end
      DRAIN: begin
        state_nxt_s = CAPTURE;
      end
      CAPTURE: begin
        state_nxt_s = OUTPUT;
      end
      OUTPUT: begin
        if (out_valid && out_ready) begin
          state_nxt_s = FEED;
        end else begin
          state_nxt_s = OUTPUT;
        end
      end
      default: begin
        state_nxt_s = FEED;
      end
    endcase
  end

  // Output/datapath next values; operands default to zero so bubbles add nothing.
  always_comb begin
    cnt_nxt_s       = cnt_r;
    pe_a_nxt_s      = {DATA_WIDTH{1'b0}};
    pe_b_nxt_s      = {DATA_WIDTH{1'b0}};
    pe_clear_nxt_s  = 1'b0;
    out_valid_nxt_s = out_valid;
    out_data_nxt_s  = out_data;
    case (state_r)
      FEED: begin
        if (accept_s) begin
          pe_a_nxt_s = in_a;
          pe_b_nxt_s = in_b;
          if (last_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      DRAIN: begin
        cnt_nxt_s = cnt_r;
      end
      CAPTURE: begin
        // The last product was accumulated at the previous edge, so the
        // PE result is final and stable here.
        out_data_nxt_s  = pe_result;
        out_valid_nxt_s = 1'b1;
        pe_clear_nxt_s  = 1'b1;
      end
      OUTPUT: begin
        if (out_valid && out_ready) begin
          out_valid_nxt_s = 1'b0;
        end else begin
          out_valid_nxt_s = out_valid;
        end
      end
      default: begin
        cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
    busy_nxt_s = (state_nxt_s != FEED) || (cnt_nxt_s != {CNT_W{1'b0}});
  end

  // Registered outputs and pair counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= {CNT_W{1'b0}};
      pe_a      <= {DATA_WIDTH{1'b0}};
      pe_b      <= {DATA_WIDTH{1'b0}};
      pe_clear  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {DATA_WIDTH{1'b0}};
      busy      <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      pe_a      <= pe_a_nxt_s;
      pe_b      <= pe_b_nxt_s;
      pe_clear  <= pe_clear_nxt_s;
      out_valid <= out_valid_nxt_s;
      out_data  <= out_data_nxt_s;
      busy      <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Bench for pe_dot_sequencer. A behavioural fp16 MAC stands in for the
// processing element, with its reset tied to reset | pe_clear. Operands
// come from a small set of exactly representable values, so real
// arithmetic gives exact half-precision results. A cycle monitor rebuilds
// the expected outputs from the accepted pairs.
module tb_pe_dot_sequencer;

  localparam int VL = 9;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] pe_a;
  logic [15:0] pe_b;
  logic        pe_clear;
  logic [15:0] pe_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  logic        u1_in_valid;
  logic        u1_in_ready;
  logic [15:0] u1_in_a;
  logic [15:0] u1_in_b;
  logic [15:0] u1_pe_a;
  logic [15:0] u1_pe_b;
  logic        u1_pe_clear;
  logic [15:0] u1_pe_result;
  logic        u1_out_valid;
  logic        u1_out_ready;
  logic [15:0] u1_out_data;
  logic        u1_busy;

  int n_vec = 0;
  int n_err = 0;

  pe_dot_sequencer #(.DATA_WIDTH(16), .VEC_LEN(VL), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .pe_a(pe_a), .pe_b(pe_b), .pe_clear(pe_clear),
    .pe_result(pe_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  pe_dot_sequencer #(.DATA_WIDTH(16), .VEC_LEN(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
    .in_a(u1_in_a), .in_b(u1_in_b), .pe_a(u1_pe_a), .pe_b(u1_pe_b),
    .pe_clear(u1_pe_clear), .pe_result(u1_pe_result), .out_valid(u1_out_valid),
    .out_ready(u1_out_ready), .out_data(u1_out_data), .busy(u1_busy)
  );

  // half -> real for normal numbers and zero
  function automatic real h2r(input logic [15:0] h);
    int  e;
    real v;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(int'(h[9:0])) / 1024.0;
    for (int i = 0; i < e - 15; i++) v = v * 2.0;
    for (int i = 0; i < 15 - e; i++) v = v / 2.0;
    if (h[15]) v = -v;
    return v;
  endfunction

  // real -> half for values exactly representable as normal halves
  function automatic logic [15:0] r2h(input real v);
    logic        s;
    real         m;
    int          e;
    int          f;
    logic [4:0]  ev;
    logic [9:0]  fv;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 15;
    for (int i = 0; i < 40 && m >= 2.0; i++) begin m = m / 2.0; e++; end
    for (int i = 0; i < 40 && m < 1.0; i++) begin m = m * 2.0; e--; end
    f  = int'((m - 1.0) * 1024.0);
    ev = e[4:0];
    fv = f[9:0];
    return {s, ev, fv};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Behavioural processing elements: result <= result + A*B
  real acc_m;
  real acc_u1;
  wire pe_rst_m  = reset | pe_clear;
  wire pe_rst_u1 = reset | u1_pe_clear;

  // main PE stand-in accumulator
  always @(posedge clk or posedge pe_rst_m) begin
    if (pe_rst_m) acc_m <= 0.0;
    else          acc_m <= acc_m + h2r(pe_a) * h2r(pe_b);
  end

  // VEC_LEN=1 PE stand-in accumulator
  always @(posedge clk or posedge pe_rst_u1) begin
    if (pe_rst_u1) acc_u1 <= 0.0;
    else           acc_u1 <= acc_u1 + h2r(u1_pe_a) * h2r(u1_pe_b);
  end

  assign pe_result    = r2h(acc_m);
  assign u1_pe_result = r2h(acc_u1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle monitor: reference model of the windowed dot-product stream
  initial begin : monitor
    logic        p_hs;
    logic        p_rst;
    logic        p_oready;
    logic [15:0] p_a;
    logic [15:0] p_b;
    int          npairs;
    int          pend;
    real         acc_sum;
    real         done_sum;
    logic        m_ov;
    logic        rose;
    logic [15:0] exp_data;
    npairs = 0; pend = 0; acc_sum = 0.0; done_sum = 0.0;
    m_ov = 1'b0; exp_data = 16'h0000;
    forever begin
      @(negedge clk);
      p_rst    = reset;
      p_hs     = in_valid && in_ready;
      p_a      = in_a;
      p_b      = in_b;
      p_oready = out_ready;
      @(posedge clk);
      #1;
      if (reset) begin
        check_eq("rst_pe_a", {16'h0000, pe_a}, 32'h0);
        check_eq("rst_pe_b", {16'h0000, pe_b}, 32'h0);
        check_eq("rst_clear", {31'h0, pe_clear}, 32'h0);
        check_eq("rst_ovalid", {31'h0, out_valid}, 32'h0);
        check_eq("rst_odata", {16'h0000, out_data}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        npairs = 0; pend = 0; acc_sum = 0.0; m_ov = 1'b0;
      end else if (!p_rst) begin
        rose = 1'b0;
        if (m_ov && p_oready) m_ov = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            m_ov     = 1'b1;
            rose     = 1'b1;
            exp_data = r2h(done_sum);
          end
        end
        if (p_hs) begin
          check_eq("pe_a", {16'h0000, pe_a}, {16'h0000, p_a});
          check_eq("pe_b", {16'h0000, pe_b}, {16'h0000, p_b});
          acc_sum = acc_sum + h2r(p_a) * h2r(p_b);
          npairs++;
          if (npairs == VL) begin
            done_sum = acc_sum;
            acc_sum  = 0.0;
            npairs   = 0;
            pend     = 2;
          end
        end else begin
          check_eq("bubble_a", {16'h0000, pe_a}, 32'h0);
          check_eq("bubble_b", {16'h0000, pe_b}, 32'h0);
        end
        check_eq("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
        if (m_ov) check_eq("out_data", {16'h0000, out_data}, {16'h0000, exp_data});
        check_eq("pe_clear", {31'h0, pe_clear}, {31'h0, rose});
        check_eq("in_ready", {31'h0, in_ready}, {31'h0, (pend == 0) && !m_ov});
        check_eq("busy", {31'h0, busy}, {31'h0, (npairs != 0) || (pend != 0) || m_ov});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    int   guard;
    logic hs;
    guard = 0;
    hs = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!hs && guard < 60) begin
      hs = in_ready;
      @(posedge clk);
      #2;
      guard++;
    end
    if (!hs) check_eq("send_timeout", 32'h0, 32'h1);
    in_valid = 1'b0;
    in_a = 16'h0000;
    in_b = 16'h0000;
  endtask

  task automatic wait_out(input string tag, input logic [15:0] exp);
    int guard;
    guard = 0;
    while (!out_valid && guard < 40) begin
      step(1);
      guard++;
    end
    check_eq({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    check_eq(tag, {16'h0000, out_data}, {16'h0000, exp});
  endtask

  logic [15:0] ops [7];

  initial begin : stim
    logic        have;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        hs;
    ops = '{16'h0000, 16'h3800, 16'h3C00, 16'h4000, 16'h4200, 16'hBC00, 16'h4400};
    reset = 1'b1;
    in_valid = 1'b0; in_a = 16'h0000; in_b = 16'h0000; out_ready = 1'b1;
    u1_in_valid = 1'b0; u1_in_a = 16'h0000; u1_in_b = 16'h0000; u1_out_ready = 1'b1;
    step(3);
    reset = 1'b0;
    step(2);

    // back-to-back ones
    for (int i = 0; i < VL; i++) send_pair(16'h3C00, 16'h3C00);
    wait_out("dot_ones", 16'h4880);
    step(3);

    // alternating bubbles: 2.0 * 0.5
    for (int i = 0; i < VL; i++) begin
      send_pair(16'h4000, 16'h3800);
      step(1);
    end
    wait_out("dot_bubbles", 16'h4880);
    step(3);

    // two windows in a row: clear must separate them
    for (int i = 0; i < VL; i++) send_pair(16'h3C00, 16'h4000);
    wait_out("dot_vec1", 16'h4C80);
    for (int i = 0; i < VL; i++) send_pair(16'h3C00, 16'h3C00);
    wait_out("dot_vec2", 16'h4880);
    step(3);

    // backpressure on the result
    out_ready = 1'b0;
    for (int i = 0; i < VL; i++) send_pair(16'h3C00, 16'h3C00);
    wait_out("dot_hold", 16'h4880);
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_data", {16'h0000, out_data}, 32'h4880);
      check_eq("hold_valid", {31'h0, out_valid}, 32'h1);
      check_eq("hold_in_ready", {31'h0, in_ready}, 32'h0);
      check_eq("hold_busy", {31'h0, busy}, 32'h1);
      step(1);
    end
    out_ready = 1'b1;
    step(1);
    check_eq("release_valid", {31'h0, out_valid}, 32'h0);
    check_eq("release_in_ready", {31'h0, in_ready}, 32'h1);
    step(2);

    // reset in the middle of a window
    for (int i = 0; i < 4; i++) send_pair(16'h3C00, 16'h3C00);
    reset = 1'b1;
    step(2);
    check_eq("mid_rst_pe_a", {16'h0000, pe_a}, 32'h0);
    check_eq("mid_rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    step(1);
    for (int i = 0; i < VL; i++) send_pair(16'h3C00, 16'h3C00);
    wait_out("dot_after_rst", 16'h4880);
    step(3);

    // VEC_LEN=1 instance: one pair completes a window
    u1_in_valid = 1'b1; u1_in_a = 16'h4200; u1_in_b = 16'h4000;
    check_eq("u1_in_ready", {31'h0, u1_in_ready}, 32'h1);
    step(1);
    u1_in_valid = 1'b0; u1_in_a = 16'h0000; u1_in_b = 16'h0000;
    check_eq("u1_pe_a", {16'h0000, u1_pe_a}, 32'h4200);
    check_eq("u1_drain_ready", {31'h0, u1_in_ready}, 32'h0);
    step(1);
    check_eq("u1_not_yet", {31'h0, u1_out_valid}, 32'h0);
    step(1);
    check_eq("u1_valid", {31'h0, u1_out_valid}, 32'h1);
    check_eq("u1_data", {16'h0000, u1_out_data}, 32'h4600);
    check_eq("u1_clear", {31'h0, u1_pe_clear}, 32'h1);
    step(1);
    check_eq("u1_valid_drop", {31'h0, u1_out_valid}, 32'h0);
    check_eq("u1_clear_drop", {31'h0, u1_pe_clear}, 32'h0);
    check_eq("u1_ready_back", {31'h0, u1_in_ready}, 32'h1);

    // randomized traffic; source holds each pair until accepted
    have = 1'b0; ra = 16'h0000; rb = 16'h0000;
    for (int c = 0; c < 600; c++) begin
      if (!have && ($urandom_range(0, 9) < 7)) begin
        ra = ops[$urandom_range(0, 6)];
        rb = ops[$urandom_range(0, 6)];
        have = 1'b1;
      end
      in_valid  = have;
      in_a      = have ? ra : 16'h0000;
      in_b      = have ? rb : 16'h0000;
      out_ready = ($urandom_range(0, 1) == 1);
      hs = in_valid && in_ready;
      step(1);
      if (hs) have = 1'b0;
    end
    in_valid = 1'b0; in_a = 16'h0000; in_b = 16'h0000; out_ready = 1'b1;
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
